// File: rtl/dir_dato_pkg.sv
// rtl/dir_dato_pkg.sv - state encoding and per-state strobe patterns for the DIR_DATO bus sequencer
package dir_dato_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_REC  = 3'd4;

  typedef enum logic [2:0] {
    IDLE = S_IDLE,
    ADDR = S_ADDR,
    GAP  = S_GAP,
    DATA = S_DATA,
    REC  = S_REC
  } estado_t;

  // Strobe patterns packed as {CS_n, AD_n, RD_n, WR_n}
  localparam logic [3:0] STB_IDLE    = 4'b1111;
  localparam logic [3:0] STB_ADDR    = 4'b0011;
  localparam logic [3:0] STB_GAP     = 4'b0111;
  localparam logic [3:0] STB_DATA_WR = 4'b0110;
  localparam logic [3:0] STB_DATA_RD = 4'b0101;
  localparam logic [3:0] STB_REC     = 4'b1111;

  function automatic logic [3:0] patron(input estado_t e, input logic wr);
    logic [3:0] p;
    p = STB_IDLE;
    case (e)
      ADDR:    p = STB_ADDR;
      GAP:     p = STB_GAP;
      DATA:    p = wr ? STB_DATA_WR : STB_DATA_RD;
      REC:     p = STB_REC;
      default: p = STB_IDLE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/dd_temporizador_fase.sv
// rtl/dd_temporizador_fase.sv - bus phase counter, pulses ultimo on the last cycle of a phase
module dd_temporizador_fase
  import dir_dato_pkg::*;
#(
  parameter int T_PH = 32
) (
  input  logic reloj,
  input  logic resetM,
  input  logic clr,
  output logic ultimo
);

  localparam int TW = (T_PH > 1) ? $clog2(T_PH) : 1;

  logic [TW-1:0] cuenta;

  always_ff @(posedge reloj) begin
    if (resetM || clr || ultimo) begin
      cuenta <= '0;
    end else begin
      cuenta <= cuenta + TW'(1);
    end
  end

  assign ultimo = (cuenta == TW'(T_PH - 1));

endmodule

// File: rtl/dir_dato_secuenciador.sv
// rtl/dir_dato_secuenciador.sv - multiplexed address/data burst sequencer for the shared DIR_DATO pins
module dir_dato_secuenciador
  import dir_dato_pkg::*;
#(
  parameter int DW   = 8,
  parameter int N_CH = 9,
  parameter int T_PH = 32,
  parameter int CW   = $clog2(N_CH + 1)
) (
  input  logic                 reloj,
  input  logic                 resetM,
  input  logic                 start,
  input  logic                 escribir,
  input  logic [DW-1:0]        dir_base,
  input  logic [CW-1:0]        n_ch,
  input  logic [N_CH*DW-1:0]   datos_wr,
  output logic [N_CH*DW-1:0]   datos_rd,
  output logic [N_CH-1:0]      rd_valido,
  output logic [DW-1:0]        dd_out,
  output logic                 dd_oe,
  input  logic [DW-1:0]        dd_in,
  output logic                 AD_n,
  output logic                 CS_n,
  output logic                 RD_n,
  output logic                 WR_n,
  output logic                 ocupado,
  output logic                 hecho
);

  estado_t               estado, estado_sig;
  logic [CW-1:0]         idx, idx_sig;
  logic [CW-1:0]         n_r, n_lat;
  logic                  es_escr;
  logic [DW-1:0]         base_r;
  logic [N_CH*DW-1:0]    shadow;
  logic                  ultimo;
  logic                  acepta, vacio, fin;
  logic                  wr_sig, oe_sig;
  logic [DW-1:0]         base_sig, dout_sig;
  logic [3:0]            stb_sig;

  dd_temporizador_fase #(.T_PH(T_PH)) u_fase (
    .reloj  (reloj),
    .resetM (resetM),
    .clr    (estado == IDLE),
    .ultimo (ultimo)
  );

  assign n_lat = (n_ch > CW'(N_CH)) ? CW'(N_CH) : n_ch;

  always_comb begin
    estado_sig = estado;
    idx_sig    = idx;
    acepta     = 1'b0;
    vacio      = 1'b0;
    fin        = 1'b0;
    unique case (estado)
      IDLE: begin
        if (start) begin
          if (n_ch != '0) begin
            acepta     = 1'b1;
            estado_sig = ADDR;
            idx_sig    = '0;
          end else begin
            vacio = 1'b1;
          end
        end
      end
      ADDR: if (ultimo) estado_sig = GAP;
      GAP:  if (ultimo) estado_sig = DATA;
      DATA: if (ultimo) estado_sig = REC;
      REC: begin
        if (ultimo) begin
          if (idx == n_r - CW'(1)) begin
            estado_sig = IDLE;
            fin        = 1'b1;
          end else begin
            estado_sig = ADDR;
            idx_sig    = idx + CW'(1);
          end
        end
      end
      default: estado_sig = IDLE;
    endcase

    // Outputs are precomputed for the state being entered so the registers line up with it
    wr_sig   = acepta ? escribir : es_escr;
    base_sig = acepta ? dir_base : base_r;
    stb_sig  = patron(estado_sig, wr_sig);
    oe_sig   = (estado_sig == ADDR) || ((estado_sig == DATA) && wr_sig);
    dout_sig = '0;
    if (estado_sig == ADDR) begin
      dout_sig = base_sig + DW'(idx_sig);
    end else if ((estado_sig == DATA) && wr_sig) begin
      dout_sig = shadow[int'(idx_sig)*DW +: DW];
    end
  end

  always_ff @(posedge reloj) begin
    if (resetM) begin
      estado    <= IDLE;
      idx       <= '0;
      n_r       <= '0;
      es_escr   <= 1'b0;
      base_r    <= '0;
      shadow    <= '0;
      datos_rd  <= '0;
      rd_valido <= '0;
      dd_out    <= '0;
      dd_oe     <= 1'b0;
      CS_n      <= 1'b1;
      AD_n      <= 1'b1;
      RD_n      <= 1'b1;
      WR_n      <= 1'b1;
      ocupado   <= 1'b0;
      hecho     <= 1'b0;
    end else begin
      estado                  <= estado_sig;
      idx                     <= idx_sig;
      {CS_n, AD_n, RD_n, WR_n} <= stb_sig;
      dd_oe                   <= oe_sig;
      dd_out                  <= dout_sig;
      ocupado                 <= (estado_sig != IDLE);
      hecho                   <= fin | vacio;
      if (acepta) begin
        es_escr   <= escribir;
        base_r    <= dir_base;
        n_r       <= n_lat;
        shadow    <= datos_wr;
        rd_valido <= '0;
      end
      if (vacio) begin
        rd_valido <= '0;
      end
      // Read data is taken at the very end of the data phase, when the device has settled longest
      if ((estado == DATA) && ultimo && !es_escr) begin
        datos_rd[int'(idx)*DW +: DW] <= dd_in;
        rd_valido[idx]               <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dir_dato_secuenciador.sv
// tb/tb_dir_dato_secuenciador.sv - bench for dir_dato_secuenciador at T_PH=4 and T_PH=32
module tb_dir_dato_secuenciador;

  localparam int DW   = 8;
  localparam int N_CH = 9;
  localparam int CW   = $clog2(N_CH + 1);
  localparam int W    = N_CH * DW;
  localparam int TA   = 4;
  localparam int TB   = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   resetM, start, escribir;
  logic [DW-1:0]          dir_base;
  logic [CW-1:0]          n_ch;
  logic [W-1:0]           datos_wr;
  logic [1:0][DW-1:0]     dd_in_x, dd_out_x;
  logic [1:0][W-1:0]      datos_rd_x;
  logic [1:0][N_CH-1:0]   rd_valido_x;
  logic [1:0]             dd_oe_x, ad_n_x, cs_n_x, rd_n_x, wr_n_x, ocupado_x, hecho_x;

  dir_dato_secuenciador #(.DW(DW), .N_CH(N_CH), .T_PH(TA), .CW(CW)) u_a (
    .reloj(clk), .resetM(resetM), .start(start), .escribir(escribir), .dir_base(dir_base),
    .n_ch(n_ch), .datos_wr(datos_wr), .datos_rd(datos_rd_x[0]), .rd_valido(rd_valido_x[0]),
    .dd_out(dd_out_x[0]), .dd_oe(dd_oe_x[0]), .dd_in(dd_in_x[0]), .AD_n(ad_n_x[0]),
    .CS_n(cs_n_x[0]), .RD_n(rd_n_x[0]), .WR_n(wr_n_x[0]), .ocupado(ocupado_x[0]), .hecho(hecho_x[0])
  );

  dir_dato_secuenciador #(.DW(DW), .N_CH(N_CH), .T_PH(TB), .CW(CW)) u_b (
    .reloj(clk), .resetM(resetM), .start(start), .escribir(escribir), .dir_base(dir_base),
    .n_ch(n_ch), .datos_wr(datos_wr), .datos_rd(datos_rd_x[1]), .rd_valido(rd_valido_x[1]),
    .dd_out(dd_out_x[1]), .dd_oe(dd_oe_x[1]), .dd_in(dd_in_x[1]), .AD_n(ad_n_x[1]),
    .CS_n(cs_n_x[1]), .RD_n(rd_n_x[1]), .WR_n(wr_n_x[1]), .ocupado(ocupado_x[1]), .hecho(hecho_x[1])
  );

  // Reference model: one burst is a flat timeline of 4*T cycles per access
  bit             m_busy [2];
  int             m_el   [2];
  int             m_n    [2];
  bit             m_wr   [2];
  logic [DW-1:0]  m_base [2];
  logic [W-1:0]   m_sh   [2];
  logic [W-1:0]   m_rd   [2];
  logic [N_CH-1:0] m_vld [2];
  bit             m_hecho[2];

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int c0    = 0;
  bit pat   = 1'b0;

  logic [1:0][127:0] addr_log, data_log;
  int  na [2];
  int  nd [2];
  int  h_cyc [2];
  int  h_cnt [2];
  logic [1:0] prev_ad, prev_wr;

  function automatic int tph(input int i);
    return (i == 0) ? TA : TB;
  endfunction

  task automatic chk(input string nm, input int i, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h, need %0h (cycle %0d)", nm, i, act, exp, cyc);
    end
  endtask

  task automatic mdl_edge(input int i);
    int t, e, k, ph, w;
    t = tph(i);
    m_hecho[i] = 1'b0;
    if (resetM) begin
      m_busy[i] = 1'b0;
      m_rd[i]   = '0;
      m_vld[i]  = '0;
    end else if (m_busy[i]) begin
      e  = m_el[i];
      k  = e / (4 * t);
      ph = (e % (4 * t)) / t;
      w  = e % t;
      if (!m_wr[i] && ph == 2 && w == t - 1) begin
        m_rd[i][k*DW +: DW] = dd_in_x[i];
        m_vld[i][k]         = 1'b1;
      end
      m_el[i]++;
      if (m_el[i] == 4 * t * m_n[i]) begin
        m_busy[i]  = 1'b0;
        m_hecho[i] = 1'b1;
      end
    end else if (start) begin
      m_vld[i] = '0;
      if (n_ch == '0) begin
        m_hecho[i] = 1'b1;
      end else begin
        m_busy[i] = 1'b1;
        m_el[i]   = 0;
        m_n[i]    = (int'(n_ch) > N_CH) ? N_CH : int'(n_ch);
        m_wr[i]   = escribir;
        m_base[i] = dir_base;
        m_sh[i]   = datos_wr;
      end
    end
  endtask

  task automatic step();
    int t, k, ph;
    logic e_cs, e_ad, e_rd, e_wr, e_oe;
    logic [DW-1:0] e_out;
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) mdl_edge(i);
    #1;
    for (int i = 0; i < 2; i++) begin
      e_cs = 1'b1; e_ad = 1'b1; e_rd = 1'b1; e_wr = 1'b1; e_oe = 1'b0; e_out = '0;
      if (m_busy[i]) begin
        t  = tph(i);
        k  = m_el[i] / (4 * t);
        ph = (m_el[i] % (4 * t)) / t;
        e_cs  = (ph == 3);
        e_ad  = (ph != 0);
        e_rd  = !(ph == 2 && !m_wr[i]);
        e_wr  = !(ph == 2 && m_wr[i]);
        e_oe  = (ph == 0) || (ph == 2 && m_wr[i]);
        e_out = (ph == 0) ? m_base[i] + DW'(k) : m_sh[i][k*DW +: DW];
      end
      chk("CS_n", i, cs_n_x[i], e_cs);
      chk("AD_n", i, ad_n_x[i], e_ad);
      chk("RD_n", i, rd_n_x[i], e_rd);
      chk("WR_n", i, wr_n_x[i], e_wr);
      chk("dd_oe", i, dd_oe_x[i], e_oe);
      if (e_oe) chk("dd_out", i, dd_out_x[i], e_out);
      chk("ocupado", i, ocupado_x[i], m_busy[i]);
      chk("hecho", i, hecho_x[i], m_hecho[i]);
      chk("datos_rd", i, datos_rd_x[i], m_rd[i]);
      chk("rd_valido", i, rd_valido_x[i], m_vld[i]);
      chk("oe_with_rd", i, dd_oe_x[i] & ~rd_n_x[i], 0);
      chk("strobe_overlap", i, (int'(!ad_n_x[i]) + int'(!rd_n_x[i]) + int'(!wr_n_x[i])) > 1, 0);
      if (!ad_n_x[i] && prev_ad[i]) begin
        addr_log[i] = {addr_log[i][119:0], dd_out_x[i]};
        na[i]++;
      end
      if (!wr_n_x[i] && prev_wr[i]) begin
        data_log[i] = {data_log[i][119:0], dd_out_x[i]};
        nd[i]++;
      end
      if (hecho_x[i]) begin
        h_cyc[i] = cyc;
        h_cnt[i]++;
      end
      prev_ad[i] = ad_n_x[i];
      prev_wr[i] = wr_n_x[i];
      if (pat && m_busy[i]) dd_in_x[i] = 8'hA0 + DW'(m_el[i] / (4 * tph(i)));
      else                  dd_in_x[i] = DW'($urandom);
    end
  endtask

  task automatic clear_logs();
    addr_log = '0; data_log = '0;
    for (int i = 0; i < 2; i++) begin
      na[i] = 0; nd[i] = 0; h_cyc[i] = -1; h_cnt[i] = 0;
    end
  endtask

  task automatic launch(input bit wr, input logic [DW-1:0] base, input int n, input logic [W-1:0] d);
    escribir = wr; dir_base = base; n_ch = CW'(n); datos_wr = d; start = 1'b1;
    clear_logs();
    c0 = cyc;
    step();
    start = 1'b0;
    escribir = 1'($urandom); dir_base = DW'($urandom); n_ch = CW'($urandom); datos_wr = W'({$urandom, $urandom, $urandom});
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((ocupado_x != 2'b00 || m_busy[0] || m_busy[1]) && n < bound) begin
      step();
      n++;
    end
    if (n >= bound) begin
      n_vec++; n_bad++;
      $display("FAIL wait_idle: still busy after %0d cycles, need idle", bound);
    end
    step();
  endtask

  initial begin
    resetM = 1'b1; start = 1'b0; escribir = 1'b0; dir_base = '0; n_ch = '0; datos_wr = '0;
    dd_in_x = '0; prev_ad = 2'b11; prev_wr = 2'b11;
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_el[i] = 0; m_n[i] = 0; m_wr[i] = 0; m_base[i] = '0;
      m_sh[i] = '0; m_rd[i] = '0; m_vld[i] = '0; m_hecho[i] = 0;
    end
    clear_logs();

    repeat (10) step();
    for (int i = 0; i < 2; i++) begin
      chk("rst_strobes", i, {cs_n_x[i], ad_n_x[i], rd_n_x[i], wr_n_x[i]}, 4'b1111);
      chk("rst_dd_oe", i, dd_oe_x[i], 0);
      chk("rst_dd_out", i, dd_out_x[i], 0);
      chk("rst_datos_rd", i, datos_rd_x[i], 0);
      chk("rst_flags", i, {ocupado_x[i], hecho_x[i], rd_valido_x[i]}, 0);
    end
    resetM = 1'b0;
    step();

    launch(1'b1, 8'h21, 3, W'(24'h504030));
    wait_idle(2000);
    for (int i = 0; i < 2; i++) begin
      chk("wr_addrs", i, addr_log[i], 128'h212223);
      chk("wr_data", i, data_log[i], 128'h304050);
    end
    chk("wr_latency", 0, h_cyc[0] - c0, 49);
    chk("wr_latency", 1, h_cyc[1] - c0, 385);

    pat = 1'b1;
    launch(1'b0, 8'h10, 9, '0);
    wait_idle(3000);
    pat = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("rd_data", i, datos_rd_x[i], 72'hA8A7A6A5A4A3A2A1A0);
      chk("rd_valid", i, rd_valido_x[i], 9'h1FF);
      chk("rd_addr_count", i, na[i], 9);
    end
    chk("rd_latency", 0, h_cyc[0] - c0, 145);
    chk("rd_latency", 1, h_cyc[1] - c0, 1153);

    launch(1'b1, 8'h55, 0, '1);
    for (int i = 0; i < 2; i++) begin
      chk("n0_hecho", i, hecho_x[i], 1);
      chk("n0_idle", i, {ocupado_x[i], cs_n_x[i], ad_n_x[i]}, 3'b011);
      chk("n0_rd_valido", i, rd_valido_x[i], 0);
    end
    step();
    for (int i = 0; i < 2; i++) chk("n0_pulse_end", i, {hecho_x[i], na[i] != 0}, 0);

    launch(1'b1, 8'hFE, 15, W'({$urandom, $urandom, $urandom}));
    wait_idle(3000);
    for (int i = 0; i < 2; i++) begin
      chk("wrap_addrs", i, addr_log[i], 128'hFEFF00010203040506);
      chk("wrap_count", i, na[i], 9);
      chk("wrap_keeps_rd", i, datos_rd_x[i], 72'hA8A7A6A5A4A3A2A1A0);
    end
    chk("wrap_latency", 0, h_cyc[0] - c0, 145);

    launch(1'b0, 8'h40, 2, '0);
    repeat (20) step();
    escribir = 1'b1; dir_base = 8'h99; n_ch = CW'(5); start = 1'b1;
    step();
    start = 1'b0;
    wait_idle(2000);
    for (int i = 0; i < 2; i++) chk("busy_start_addrs", i, addr_log[i], 128'h4041);
    chk("busy_start_latency", 0, h_cyc[0] - c0, 33);
    chk("busy_start_latency", 1, h_cyc[1] - c0, 257);

    launch(1'b1, 8'h60, 4, W'({$urandom, $urandom, $urandom}));
    repeat (42) step();
    chk("pre_rst_wr_low", 0, wr_n_x[0], 0);
    resetM = 1'b1;
    step();
    resetM = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("mid_rst_strobes", i, {cs_n_x[i], ad_n_x[i], rd_n_x[i], wr_n_x[i], dd_oe_x[i], ocupado_x[i]}, 6'b111100);
    end
    clear_logs();
    repeat (300) step();
    for (int i = 0; i < 2; i++) chk("mid_rst_no_hecho", i, h_cnt[i], 0);

    for (int s = 0; s < 20000; s++) begin
      start    = ($urandom_range(0, 15) == 0);
      escribir = 1'($urandom);
      dir_base = DW'($urandom);
      n_ch     = CW'($urandom_range(0, 15));
      datos_wr = W'({$urandom, $urandom, $urandom});
      resetM   = ($urandom_range(0, 2999) == 0);
      step();
    end
    resetM = 1'b0;
    start  = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
